// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RISC-V M-extension multiply/divide unit.
//   Multiplies finish in 2 cycles. Divides and remainders use a restoring
//   divider that retires one quotient bit per cycle. Divide-by-zero and
//   signed overflow are resolved at accept time in a single cycle.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   in_valid/ready   request handshake; in_ready is high only in IDLE
//   op[2:0]          MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   x, y             rs1 / rs2 operands, captured on accept
//   flush            synchronous kill of in-flight or pending result
//   out_valid/ready  result handshake; result is held while out_valid=1
//   result           registered result
//   busy             unit is not IDLE
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  // Captured operation: op[1:0] selects mul half / rem-vs-quotient.
  logic [1:0]         r_op;
  // r_a: multiplicand, or dividend magnitude shifting into the quotient.
  logic [XLEN-1:0]    r_a;
  // r_b: multiplier (low XLEN bits), or divisor magnitude (XLEN+1 bits).
  logic [XLEN:0]      r_b;
  logic [XLEN-1:0]    r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [XLEN-1:0]    r_result;

  logic               w_accept;
  logic               w_signed_div;
  logic               w_x_neg;
  logic               w_y_neg;
  logic [XLEN:0]      w_x_ext;
  logic [XLEN:0]      w_y_ext;
  logic [XLEN:0]      w_x_mag;
  logic [XLEN:0]      w_y_mag;
  logic               w_y_zero;
  logic               w_ovf;
  logic               w_special;
  logic [XLEN-1:0]    w_special_res;

  logic [PW-1:0]      w_mx;
  logic [PW-1:0]      w_my;
  logic [PW-1:0]      w_prod;
  logic [XLEN-1:0]    w_mul_res;

  logic [XLEN:0]      w_shift;
  logic [XLEN:0]      w_diff;
  logic               w_ge;
  logic [XLEN:0]      w_rem_nxt;
  logic [XLEN-1:0]    w_rem_trunc;
  logic [XLEN-1:0]    w_quo_nxt;
  logic [XLEN-1:0]    w_q_fix;
  logic [XLEN-1:0]    w_r_fix;
  logic [XLEN-1:0]    w_div_res;
  logic               w_div_last;

  // Outputs decoded from registered state only.
  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;

  assign w_accept  = in_valid & (r_state == S_IDLE) & ~flush;

  // Divide operand preparation on the raw inputs (used only on accept).
  assign w_signed_div = ~op[0];
  assign w_x_neg      = w_signed_div & x[XLEN-1];
  assign w_y_neg      = w_signed_div & y[XLEN-1];
  assign w_x_ext      = {w_x_neg, x};
  assign w_y_ext      = {w_y_neg, y};
  // XLEN+1-bit magnitudes so that |-2^(XLEN-1)| is representable.
  assign w_x_mag      = w_x_neg ? -w_x_ext : w_x_ext;
  assign w_y_mag      = w_y_neg ? -w_y_ext : w_y_ext;

  assign w_y_zero  = (y == '0);
  assign w_ovf     = w_signed_div & (x == {1'b1, {(XLEN-1){1'b0}}}) & (&y);
  assign w_special = op[2] & (w_y_zero | w_ovf);

  // Results that bypass the divider entirely.
  always_comb begin
    w_special_res = '0;
    if (w_y_zero) begin
      w_special_res = op[1] ? x : '1;
    end else begin
      w_special_res = op[1] ? '0 : x;
    end
  end

  // Multiplier: x signed for MUL/MULH/MULHSU, y signed for MUL/MULH.
  assign w_mx      = (r_op != 2'b11) ? {{XLEN{r_a[XLEN-1]}}, r_a}
                                     : {{XLEN{1'b0}}, r_a};
  assign w_my      = (~r_op[1]) ? {{XLEN{r_b[XLEN-1]}}, r_b[XLEN-1:0]}
                                : {{XLEN{1'b0}}, r_b[XLEN-1:0]};
  assign w_prod    = w_mx * w_my;
  assign w_mul_res = (r_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[PW-1:XLEN];

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  assign w_shift     = {r_rem, r_a[XLEN-1]};
  assign w_ge        = (w_shift >= r_b);
  assign w_diff      = w_shift - r_b;
  assign w_rem_nxt   = w_ge ? w_diff : w_shift;
  assign w_rem_trunc = XLEN'(w_rem_nxt);
  assign w_quo_nxt   = {r_a[XLEN-2:0], w_ge};
  assign w_div_last  = (r_cnt == CNT_W'(1));

  // Sign fix-up applied to the values produced by the final step.
  assign w_q_fix   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_r_fix   = r_neg_r ? -w_rem_trunc : w_rem_trunc;
  assign w_div_res = r_op[1] ? w_r_fix : w_q_fix;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!op[2]) begin
            w_state_nxt = S_MUL;
          end else if (w_special) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_DIV;
          end
        end
      end
      S_MUL:  w_state_nxt = S_DONE;
      S_DIV:  if (w_div_last) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op <= op[1:0];
            if (w_special) begin
              r_result <= w_special_res;
            end else if (op[2]) begin
              r_a     <= XLEN'(w_x_mag);
              r_b     <= w_y_mag;
              r_rem   <= '0;
              r_cnt   <= CNT_W'(XLEN);
              r_neg_q <= w_x_neg ^ w_y_neg;
              r_neg_r <= w_x_neg;
            end else begin
              r_a <= x;
              r_b <= {1'b0, y};
            end
          end
        end
        S_MUL: begin
          r_result <= w_mul_res;
        end
        S_DIV: begin
          r_a   <= w_quo_nxt;
          r_rem <= w_rem_trunc;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_div_last) begin
            r_result <= w_div_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (XLEN=32). Latency is counted in clock
// edges from the start of the request cycle: the accept edge is edge 1.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] x;
  logic [31:0] y;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .y         (y),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request for one cycle; caller is at a negedge with the unit idle.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; x = a; y = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges until out_valid is seen at a negedge; 0 means it never came.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h exp=0", result); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [2:0]  v_op [7] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd3, 3'd2, 3'd1};
    logic [31:0] v_x  [7] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7, 32'd7};
    logic [31:0] v_y  [7] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2,
                              32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD};
    logic [31:0] v_e  [7] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                              32'd6, 32'd6, 32'hFFFFFFFF};
    int lat;
    for (int i = 0; i < 7; i++) begin
      issue(v_op[i], v_x[i], v_y[i]);
      wait_valid(lat);
      n_vec++; if (lat !== 2) begin n_err++; $display("FAIL mul_latency[%0d] got=%0d exp=2", i, lat); end
      n_vec++; if (result !== v_e[i]) begin n_err++; $display("FAIL mul_result[%0d] got=%h exp=%h", i, result, v_e[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_div();
    logic [2:0]  v_op [10] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] v_x  [10] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd100, 32'd7, 32'd7,
                               32'h80000000, 32'hFFFFFFEC, 32'h80000000, 32'h80000000};
    logic [31:0] v_y  [10] = '{32'd2, 32'd2, 32'd2, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE,
                               32'd2, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] v_e  [10] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFD, 32'd1,
                               32'hC0000000, 32'hFFFFFFFE, 32'd0, 32'h80000000};
    int lat;
    for (int i = 0; i < 10; i++) begin
      issue(v_op[i], v_x[i], v_y[i]);
      wait_valid(lat);
      n_vec++; if (lat !== 33) begin n_err++; $display("FAIL div_latency[%0d] got=%0d exp=33", i, lat); end
      n_vec++; if (result !== v_e[i]) begin n_err++; $display("FAIL div_result[%0d] got=%h exp=%h", i, result, v_e[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_special();
    logic [2:0]  v_op [6] = '{3'd4, 3'd7, 3'd4, 3'd6, 3'd5, 3'd6};
    logic [31:0] v_x  [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5, 32'hFFFFFFFB};
    logic [31:0] v_y  [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] v_e  [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB};
    int lat;
    for (int i = 0; i < 6; i++) begin
      issue(v_op[i], v_x[i], v_y[i]);
      wait_valid(lat);
      n_vec++; if (lat !== 1) begin n_err++; $display("FAIL special_latency[%0d] got=%0d exp=1", i, lat); end
      n_vec++; if (result !== v_e[i]) begin n_err++; $display("FAIL special_result[%0d] got=%h exp=%h", i, result, v_e[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(3'd0, 32'd2, 32'd3);
    wait_valid(lat);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_done_in_ready got=%b exp=0", in_ready); end
    n_vec++; if (result !== 32'd6) begin n_err++; $display("FAIL b2b_first_result got=%h exp=6", result); end
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_handoff in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    issue(3'd4, 32'd5, 32'd0);
    wait_valid(lat);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL b2b_second_latency got=%0d exp=1", lat); end
    n_vec++; if (result !== 32'hFFFFFFFF) begin n_err++; $display("FAIL b2b_second_result got=%h exp=ffffffff", result); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    issue(3'd0, 32'd3, 32'd5);
    wait_valid(lat);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL bp_latency got=%0d exp=2", lat); end
    for (int c = 0; c < 10; c++) begin
      n_vec++; if (out_valid !== 1'b1 || result !== 32'd15 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold[%0d] out_valid=%b result=%h in_ready=%b exp 1/0000000f/0", c, out_valid, result, in_ready);
      end
      op = 3'd0; x = 32'd2; y = 32'd2; in_valid = c[0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_no_stale_accept busy=%b exp=0", busy); end
  endtask

  task automatic test_flush();
    int lat;
    issue(3'd4, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_div busy=%b out_valid=%b in_ready=%b exp 0/0/1", busy, out_valid, in_ready);
    end
    issue(3'd0, 32'd3, 32'd4);
    wait_valid(lat);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL flush_mul_latency got=%0d exp=2", lat); end
    n_vec++; if (result !== 32'd12) begin n_err++; $display("FAIL flush_mul_result got=%h exp=c", result); end
    @(negedge clk);
    // Flush together with a request in IDLE.
    op = 3'd0; x = 32'd5; y = 32'd5; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin in_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_idle_accept busy=%b exp=0", busy); end
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_idle_out_valid got=%b exp=0", out_valid); end
    // Flush of a pending result leaves result untouched.
    out_ready = 1'b0;
    issue(3'd0, 32'd6, 32'd7);
    wait_valid(lat);
    n_vec++; if (result !== 32'd42) begin n_err++; $display("FAIL flush_done_pre got=%h exp=2a", result); end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd42) begin
      n_err++; $display("FAIL flush_done out_valid=%b in_ready=%b result=%h exp 0/1/2a", out_valid, in_ready, result);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    int lat;
    issue(3'd5, 32'hFFFFFFFF, 32'd2);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL areset_outputs busy=%b out_valid=%b in_ready=%b exp 0/0/1", busy, out_valid, in_ready);
    end
    n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL areset_result got=%h exp=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd5, 32'd9, 32'd3);
    wait_valid(lat);
    n_vec++; if (lat !== 33) begin n_err++; $display("FAIL areset_div_latency got=%0d exp=33", lat); end
    n_vec++; if (result !== 32'd3) begin n_err++; $display("FAIL areset_div_result got=%h exp=3", result); end
    @(negedge clk);
  endtask

  initial begin
    in_valid  = 1'b0;
    op        = 3'd0;
    x         = '0;
    y         = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
